// File: rtl/bram_bwe_pipe.sv
// Single-port block RAM with per-byte write enables, selectable read-during-write
// behaviour and optional output register. Macro BRAM_PARITY_EN adds per-byte parity.
module bram_bwe_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int OUT_REG    = 0,
    parameter int RDW_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic [DATA_WIDTH/8-1:0] bwe,
    input  logic                    ren,
`ifdef BRAM_PARITY_EN
    input  logic                    perr_clr,
    output logic                    perr,
`endif
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    rvalid
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef BRAM_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + NB;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
        $error("bram_bwe_pipe: DATA_WIDTH must be a non-zero multiple of 8");
    end

    // Stored word layout: data in [DATA_WIDTH-1:0], parity bit of byte i at DATA_WIDTH+i.
    logic [MEM_W-1:0] mem [DEPTH];
    logic [MEM_W-1:0] rd_word;
    logic [MEM_W-1:0] rdw_word;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (bwe[i]) begin
                mem[addr][8*i +: 8] <= din[8*i +: 8];
`ifdef BRAM_PARITY_EN
                mem[addr][DATA_WIDTH+i] <= ^din[8*i +: 8];
`endif
            end
        end
    end

    always_comb begin
        rd_word  = mem[addr];
        rdw_word = rd_word;
        if (RDW_MODE != 0) begin
            for (int i = 0; i < NB; i++) begin
                if (bwe[i]) begin
                    rdw_word[8*i +: 8] = din[8*i +: 8];
`ifdef BRAM_PARITY_EN
                    rdw_word[DATA_WIDTH+i] = ^din[8*i +: 8];
`endif
                end
            end
        end
    end

    logic             fin_load;
    logic [MEM_W-1:0] fin_word;

    if (OUT_REG != 0) begin : g_out_reg
        logic             s1_vld_q;
        logic             s1_vld_d;
        logic [MEM_W-1:0] s1_word_q;
        logic [MEM_W-1:0] s1_word_d;

        always_comb begin
            s1_vld_d  = ren;
            s1_word_d = ren ? rdw_word : s1_word_q;
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                s1_vld_q  <= 1'b0;
                s1_word_q <= '0;
            end else begin
                s1_vld_q  <= s1_vld_d;
                s1_word_q <= s1_word_d;
            end
        end

        assign fin_load = s1_vld_q;
        assign fin_word = s1_word_q;
    end else begin : g_no_out_reg
        assign fin_load = ren;
        assign fin_word = rdw_word;
    end

    logic                  rvalid_q;
    logic                  rvalid_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;

    // dout only moves when a read lands, so it holds the last result otherwise.
    always_comb begin
        rvalid_d = fin_load;
        dout_d   = fin_load ? fin_word[DATA_WIDTH-1:0] : dout_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rvalid_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            dout_q   <= dout_d;
        end
    end

    assign dout   = dout_q;
    assign rvalid = rvalid_q;

`ifdef BRAM_PARITY_EN
    logic par_bad;
    logic perr_q;
    logic perr_d;

    // A new error wins over a simultaneous clear.
    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < NB; i++) begin
            par_bad = par_bad | ((^fin_word[8*i +: 8]) != fin_word[DATA_WIDTH+i]);
        end
        perr_d = perr_q;
        if (fin_load && par_bad) begin
            perr_d = 1'b1;
        end else if (perr_clr) begin
            perr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign perr = perr_q;
`endif

endmodule

// File: tb/tb_bram_bwe_pipe.sv
// Bench for bram_bwe_pipe: a read-first/latency-1 instance and a write-first/latency-2
// instance share stimulus and are checked against a queue-based behavioural model.
module tb_bram_bwe_pipe;
`ifdef BRAM_PARITY_EN
    localparam int DW = 16;
    localparam int AW = 4;
`else
    localparam int DW = 32;
    localparam int AW = 10;
`endif
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk    = 1'b0;
    logic          resetn = 1'b1;
    logic [AW-1:0] addr   = '0;
    logic [DW-1:0] din    = '0;
    logic [NB-1:0] bwe    = '0;
    logic          ren    = 1'b0;
    logic [DW-1:0] dout_a, dout_b;
    logic          rvalid_a, rvalid_b;
`ifdef BRAM_PARITY_EN
    logic          perr_clr = 1'b0;
    logic          perr_a, perr_b;
    logic          e_pe_a = 1'b0, e_pe_b = 1'b0;
`endif

    always #5 clk = ~clk;

    bram_bwe_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0), .RDW_MODE(0)) u_a (
        .clk(clk), .resetn(resetn), .addr(addr), .din(din), .bwe(bwe), .ren(ren),
`ifdef BRAM_PARITY_EN
        .perr_clr(perr_clr), .perr(perr_a),
`endif
        .dout(dout_a), .rvalid(rvalid_a));

    bram_bwe_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1), .RDW_MODE(1)) u_b (
        .clk(clk), .resetn(resetn), .addr(addr), .din(din), .bwe(bwe), .ren(ren),
`ifdef BRAM_PARITY_EN
        .perr_clr(perr_clr), .perr(perr_b),
`endif
        .dout(dout_b), .rvalid(rvalid_b));

    // Reference model: memory image, corrupted-byte masks, pending read results per instance.
    typedef struct { int due; logic [DW-1:0] val; bit err; } rd_t;
    rd_t           qa[$];
    rd_t           qb[$];
    logic [DW-1:0] mm [DEPTH];
    logic [NB-1:0] cm [DEPTH];
    int            cyc   = 0;
    int            ncmp  = 0;
    int            nfail = 0;
    logic          e_rv_a = 1'b0, e_rv_b = 1'b0;
    logic [DW-1:0] e_do_a = '0, e_do_b = '0;

    task automatic model_reset();
        qa.delete();
        qb.delete();
        e_rv_a = 1'b0;
        e_rv_b = 1'b0;
        e_do_a = '0;
        e_do_b = '0;
`ifdef BRAM_PARITY_EN
        e_pe_a = 1'b0;
        e_pe_b = 1'b0;
`endif
    endtask

    // One clock: drive inputs, advance the model, leave expectations for #1 after the edge.
    task automatic step(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NB-1:0] b, input logic r);
        logic [DW-1:0] old_w, new_w;
        bit            clr_s;
        addr = a; din = d; bwe = b; ren = r;
        @(posedge clk);
        cyc++;
        clr_s = 1'b0;
`ifdef BRAM_PARITY_EN
        clr_s = perr_clr;
`endif
        if (resetn) begin
            old_w = mm[a];
            new_w = old_w;
            for (int i = 0; i < NB; i++) if (b[i]) new_w[8*i +: 8] = d[8*i +: 8];
            if (r) begin
                qa.push_back('{cyc, old_w, |cm[a]});
                qb.push_back('{cyc + 1, new_w, |(cm[a] & ~b)});
            end
            mm[a] = new_w;
            cm[a] = cm[a] & ~b;
        end
        #1;
        e_rv_a = 1'b0;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            e_rv_a = 1'b1;
            e_do_a = qa[0].val;
`ifdef BRAM_PARITY_EN
            if (qa[0].err) e_pe_a = 1'b1; else if (clr_s) e_pe_a = 1'b0;
`endif
            void'(qa.pop_front());
        end else begin
`ifdef BRAM_PARITY_EN
            if (clr_s) e_pe_a = 1'b0;
`endif
        end
        e_rv_b = 1'b0;
        if (qb.size() > 0 && qb[0].due == cyc) begin
            e_rv_b = 1'b1;
            e_do_b = qb[0].val;
`ifdef BRAM_PARITY_EN
            if (qb[0].err) e_pe_b = 1'b1; else if (clr_s) e_pe_b = 1'b0;
`endif
            void'(qb.pop_front());
        end else begin
`ifdef BRAM_PARITY_EN
            if (clr_s) e_pe_b = 1'b0;
`endif
        end
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step('0, '0, '0, 1'b0);
            ncmp++;
            if (rvalid_a !== 1'b0 || dout_a !== '0) begin
                nfail++;
                $display("FAIL reset A: rvalid=%0b dout=%h, required rvalid=0 dout=0", rvalid_a, dout_a);
            end
            ncmp++;
            if (rvalid_b !== 1'b0 || dout_b !== '0) begin
                nfail++;
                $display("FAIL reset B: rvalid=%0b dout=%h, required rvalid=0 dout=0", rvalid_b, dout_b);
            end
        end
        resetn = 1'b1;
    endtask

    task automatic test_full_write();
        step(AW'(5), DW'(32'hDEADBEEF), '1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(AW'(5), '0, '0, (k == 0));
            ncmp++;
            if (rvalid_a !== e_rv_a || dout_a !== e_do_a) begin
                nfail++;
                $display("FAIL full_write A k=%0d: rvalid=%0b dout=%h, required rvalid=%0b dout=%h", k, rvalid_a, dout_a, e_rv_a, e_do_a);
            end
            ncmp++;
            if (rvalid_b !== e_rv_b || dout_b !== e_do_b) begin
                nfail++;
                $display("FAIL full_write B k=%0d: rvalid=%0b dout=%h, required rvalid=%0b dout=%h", k, rvalid_b, dout_b, e_rv_b, e_do_b);
            end
        end
    endtask

    task automatic test_byte_enables();
        step(AW'(7), DW'(32'h11223344), NB'(4'hF), 1'b0);
        step(AW'(7), DW'(32'hAABBCCDD), NB'(4'b0101), 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(AW'(7), '0, '0, (k == 0));
            ncmp++;
            if (rvalid_a !== e_rv_a || dout_a !== e_do_a) begin
                nfail++;
                $display("FAIL byte_en A k=%0d: rvalid=%0b dout=%h, required rvalid=%0b dout=%h", k, rvalid_a, dout_a, e_rv_a, e_do_a);
            end
            ncmp++;
            if (rvalid_b !== e_rv_b || dout_b !== e_do_b) begin
                nfail++;
                $display("FAIL byte_en B k=%0d: rvalid=%0b dout=%h, required rvalid=%0b dout=%h", k, rvalid_b, dout_b, e_rv_b, e_do_b);
            end
        end
    endtask

    task automatic test_rdw();
        step(AW'(3), DW'(32'h00000001), '1, 1'b0);
        step(AW'(3), DW'(32'hCAFEF00D), '1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) step(AW'(3), '0, '0, 1'b1);
            else if (k > 1) step(AW'(3), '0, '0, 1'b0);
            ncmp++;
            if (rvalid_a !== e_rv_a || dout_a !== e_do_a) begin
                nfail++;
                $display("FAIL rdw A k=%0d: rvalid=%0b dout=%h, required rvalid=%0b dout=%h", k, rvalid_a, dout_a, e_rv_a, e_do_a);
            end
            ncmp++;
            if (rvalid_b !== e_rv_b || dout_b !== e_do_b) begin
                nfail++;
                $display("FAIL rdw B k=%0d: rvalid=%0b dout=%h, required rvalid=%0b dout=%h", k, rvalid_b, dout_b, e_rv_b, e_do_b);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) step(AW'(i), DW'(32'h10 + i), '1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(AW'(k < 4 ? k : 0), '0, '0, (k < 4));
            ncmp++;
            if (rvalid_a !== e_rv_a || dout_a !== e_do_a) begin
                nfail++;
                $display("FAIL b2b A k=%0d: rvalid=%0b dout=%h, required rvalid=%0b dout=%h", k, rvalid_a, dout_a, e_rv_a, e_do_a);
            end
            ncmp++;
            if (rvalid_b !== e_rv_b || dout_b !== e_do_b) begin
                nfail++;
                $display("FAIL b2b B k=%0d: rvalid=%0b dout=%h, required rvalid=%0b dout=%h", k, rvalid_b, dout_b, e_rv_b, e_do_b);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        step(AW'(9), DW'(32'h5A5AA5A5), '1, 1'b0);
        step(AW'(6), DW'(32'h0BADF00D), '1, 1'b0);
        step(AW'(6), '0, '0, 1'b1);
        // B's read is still in flight here; it must vanish.
        resetn = 1'b0;
        model_reset();
        #1;
        ncmp++;
        if (rvalid_a !== 1'b0 || dout_a !== '0 || rvalid_b !== 1'b0 || dout_b !== '0) begin
            nfail++;
            $display("FAIL mid_reset async: A rvalid=%0b dout=%h B rvalid=%0b dout=%h, required all 0", rvalid_a, dout_a, rvalid_b, dout_b);
        end
        for (int k = 0; k < 9; k++) begin
            if (k == 2) resetn = 1'b1;
            step(AW'(9), '0, '0, (k == 5));
            ncmp++;
            if (rvalid_a !== e_rv_a || dout_a !== e_do_a) begin
                nfail++;
                $display("FAIL mid_reset A k=%0d: rvalid=%0b dout=%h, required rvalid=%0b dout=%h", k, rvalid_a, dout_a, e_rv_a, e_do_a);
            end
            ncmp++;
            if (rvalid_b !== e_rv_b || dout_b !== e_do_b) begin
                nfail++;
                $display("FAIL mid_reset B k=%0d: rvalid=%0b dout=%h, required rvalid=%0b dout=%h", k, rvalid_b, dout_b, e_rv_b, e_do_b);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) step(AW'(i), DW'($urandom()), '1, 1'b0);
        for (int k = 0; k < 300; k++) begin
            step(AW'($urandom_range(0, 15)), DW'($urandom()), NB'($urandom()), 1'($urandom_range(0, 1)));
            ncmp++;
            if (rvalid_a !== e_rv_a || dout_a !== e_do_a) begin
                nfail++;
                $display("FAIL random A k=%0d: rvalid=%0b dout=%h, required rvalid=%0b dout=%h", k, rvalid_a, dout_a, e_rv_a, e_do_a);
            end
            ncmp++;
            if (rvalid_b !== e_rv_b || dout_b !== e_do_b) begin
                nfail++;
                $display("FAIL random B k=%0d: rvalid=%0b dout=%h, required rvalid=%0b dout=%h", k, rvalid_b, dout_b, e_rv_b, e_do_b);
            end
        end
        for (int k = 0; k < 3; k++) step('0, '0, '0, 1'b0);
    endtask

`ifdef BRAM_PARITY_EN
    task automatic test_parity();
        step(AW'(2), DW'(16'hA5C3), '1, 1'b0);
        step(AW'(4), DW'(16'h1234), '1, 1'b0);
        u_a.mem[2][1] = ~u_a.mem[2][1];
        u_b.mem[2][1] = ~u_b.mem[2][1];
        cm[2][0] = 1'b1;
        for (int k = 0; k < 14; k++) begin
            perr_clr = (k == 8 || k == 10);
            if (k == 0 || k == 10) step(AW'(2), '0, '0, 1'b1);
            else if (k == 4) step(AW'(4), '0, '0, 1'b1);
            else step(AW'(4), '0, '0, 1'b0);
            perr_clr = 1'b0;
            ncmp++;
            if (perr_a !== e_pe_a || rvalid_a !== e_rv_a || dout_a !== e_do_a) begin
                nfail++;
                $display("FAIL parity A k=%0d: perr=%0b rvalid=%0b dout=%h, required perr=%0b rvalid=%0b dout=%h", k, perr_a, rvalid_a, dout_a, e_pe_a, e_rv_a, e_do_a);
            end
            ncmp++;
            if (perr_b !== e_pe_b || rvalid_b !== e_rv_b || dout_b !== e_do_b) begin
                nfail++;
                $display("FAIL parity B k=%0d: perr=%0b rvalid=%0b dout=%h, required perr=%0b rvalid=%0b dout=%h", k, perr_b, rvalid_b, dout_b, e_pe_b, e_rv_b, e_do_b);
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mm[i] = '0;
            cm[i] = '0;
        end
        test_reset();
        test_full_write();
        test_byte_enables();
        test_rdw();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
`ifdef BRAM_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
